// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
// - Memory status codes, which the unit both passes through and generates locally.
// - Access-size encodings.
// - Memory depth.
// - FSM state type.
// - Local request check helper.
package load_store_unit_pkg;

    // Memory status codes (mirrors the memory block's status register)
    localparam logic [1:0] MEMORY_STATE_SUCCESS       = 2'd0;
    localparam logic [1:0] MEMORY_STATE_OUT_OF_BOUNDS = 2'd1;
    localparam logic [1:0] MEMORY_STATE_ALIGNMENT     = 2'd2;
    localparam logic [1:0] MEMORY_STATE_ERROR         = 2'd3;

    // Access sizes
    localparam logic [1:0] LSU_SIZE_BYTE    = 2'b00;
    localparam logic [1:0] LSU_SIZE_HALF    = 2'b01;
    localparam logic [1:0] LSU_SIZE_WORD    = 2'b10;
    localparam logic [1:0] LSU_SIZE_ILLEGAL = 2'b11;

    localparam int MEMORY_SIZE_WORDS = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_ERR   = 2'd3
    } lsu_state_t;

    // Local rejection.
    // - Priority order: illegal size, then misalignment, then below-base.
    function automatic logic [1:0] lsu_local_check(input logic [1:0] size,
                                                   input logic [1:0] off,
                                                   input logic       below_base);
        logic [1:0] code;
        code = MEMORY_STATE_SUCCESS;
        if (size == LSU_SIZE_ILLEGAL)
            code = MEMORY_STATE_ALIGNMENT;
        else if ((size == LSU_SIZE_HALF && off[0]) || (size == LSU_SIZE_WORD && off != 2'b00))
            code = MEMORY_STATE_ALIGNMENT;
        else if (below_base)
            code = MEMORY_STATE_OUT_OF_BOUNDS;
        return code;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response/memory bus of the load/store unit.
// Signal groups:
// - req_*: request handshake from the execute stage.
// - rsp_*: response back to the execute stage.
// - mem_*: word-addressed BRAM access.
// Modports:
// - slave: the load/store unit itself.
// - master: the environment (core + memory).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_code;

    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_w_data;
    logic [3:0]  mem_w_strb;
    logic [31:0] mem_r_data;
    logic [1:0]  mem_state;

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_code,
        output mem_r_en, mem_w_en, mem_r_addr, mem_w_addr, mem_w_data, mem_w_strb,
        input  mem_r_data, mem_state
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_code,
        input  mem_r_en, mem_w_en, mem_r_addr, mem_w_addr, mem_w_data, mem_w_strb,
        output mem_r_data, mem_state
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for sub-word accesses (purely combinational).
// Ports:
// - i_size, i_off, i_unsigned: access size, byte offset within word, zero-extend flag.
// - i_wdata: right-justified store data.
// - i_rdata: full memory read word.
// - o_strb: byte strobe.
// - o_wdata: lane-replicated store data.
// - o_rdata: selected lane, sign/zero extended.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_strb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shifted;

    // Bring the addressed lane down to bit 0
    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_strb  = 4'b0000;
        o_wdata = 32'h0;
        o_rdata = 32'h0;
        case (i_size)
            LSU_SIZE_BYTE: begin
                o_strb  = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'h0, w_shifted[7:0]}
                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            LSU_SIZE_HALF: begin
                o_strb  = 4'b0011 << i_off;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = i_unsigned ? {16'h0, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            LSU_SIZE_WORD: begin
                o_strb  = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: adapts execute-stage byte/half/word requests to single aligned word
// accesses on the BRAM, and returns extended load data plus the memory status code.
// Misaligned, illegal-size and below-base requests are answered locally.
// Ports:
// - i_clk, i_rst: clock, synchronous active-high reset.
// - i_clk_enable: run enable shared with memory; low freezes the block.
// - bus: request/response/memory bus (slave modport).
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter string       NAME      = "",
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_enable,
    load_store_unit_if.slave  bus
);
    lsu_state_t  r_state, w_next;

    logic        r_we;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_code;

    logic [31:0] w_off_addr;
    logic [1:0]  w_local_code;
    logic        w_local_err;
    logic        w_accept;
    logic        w_issue;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;

    assign w_off_addr   = bus.req_addr - BASE_ADDR;
    assign w_local_code = lsu_local_check(bus.req_size, w_off_addr[1:0], bus.req_addr < BASE_ADDR);
    assign w_local_err  = (w_local_code != MEMORY_STATE_SUCCESS);

    assign bus.req_ready = i_clk_enable && !i_rst && (r_state == ST_IDLE || r_state == ST_RESP);
    assign w_accept      = bus.req_valid && bus.req_ready;

    lsu_lane_align u_align (
        .i_size     (r_size),
        .i_off      (r_off),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (bus.mem_r_data),
        .o_strb     (w_strb),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_size     <= LSU_SIZE_BYTE;
            r_off      <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_code     <= MEMORY_STATE_SUCCESS;
        end else if (i_clk_enable) begin
            r_state <= w_next;
            if (w_accept) begin
                r_we       <= bus.req_we;
                r_size     <= bus.req_size;
                r_off      <= w_off_addr[1:0];
                r_unsigned <= bus.req_unsigned;
                r_addr     <= {w_off_addr[31:2], 2'b00};
                r_wdata    <= bus.req_wdata;
                r_code     <= w_local_code;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = w_local_err ? ST_ERR : ST_ISSUE;
            ST_ISSUE: w_next = ST_RESP;
            ST_RESP:  w_next = w_accept ? (w_local_err ? ST_ERR : ST_ISSUE) : ST_IDLE;
            ST_ERR:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // A frozen ISSUE drives nothing so the access happens exactly once, on the first enabled cycle
    assign w_issue = (r_state == ST_ISSUE) && i_clk_enable;

    always_comb begin
        bus.mem_r_en   = w_issue && !r_we;
        bus.mem_w_en   = w_issue && r_we;
        bus.mem_r_addr = (w_issue && !r_we) ? r_addr : 32'h0;
        bus.mem_w_addr = (w_issue && r_we) ? r_addr : 32'h0;
        bus.mem_w_strb = (w_issue && r_we) ? w_strb : 4'h0;
        bus.mem_w_data = (w_issue && r_we) ? w_wdata : 32'h0;
    end

    // mem_state is sticky, so it is only looked at in RESP
    always_comb begin
        bus.rsp_valid = 1'b0;
        bus.rsp_code  = MEMORY_STATE_SUCCESS;
        bus.rsp_rdata = 32'h0;
        if (i_clk_enable && r_state == ST_RESP) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_code  = bus.mem_state;
            if (!r_we && bus.mem_state == MEMORY_STATE_SUCCESS)
                bus.rsp_rdata = w_rdata;
        end else if (i_clk_enable && r_state == ST_ERR) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_code  = r_code;
        end
        bus.rsp_err = (bus.rsp_code != MEMORY_STATE_SUCCESS);
    end

    a_one_enable: assert property (@(posedge i_clk) !(bus.mem_r_en && bus.mem_w_en))
        else $error("%s: both memory enables high", NAME);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_enable = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.NAME("lsu0"), .BASE_ADDR(32'h0000_1000)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clk_enable (clk_enable),
        .bus          (bus)
    );

    // Memory environment: registered read data, sticky status
    logic [31:0] mem [0:MEMORY_SIZE_WORDS-1];
    initial for (int i = 0; i < MEMORY_SIZE_WORDS; i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            bus.mem_state  <= MEMORY_STATE_SUCCESS;
            bus.mem_r_data <= 32'h0;
        end else if (clk_enable) begin
            if (bus.mem_w_en) begin
                if (bus.mem_w_addr[31:2] < MEMORY_SIZE_WORDS) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_w_strb[b])
                            mem[bus.mem_w_addr[9:2]][8*b +: 8] <= bus.mem_w_data[8*b +: 8];
                    bus.mem_state <= MEMORY_STATE_SUCCESS;
                end else bus.mem_state <= MEMORY_STATE_OUT_OF_BOUNDS;
            end else if (bus.mem_r_en) begin
                if (bus.mem_r_addr[31:2] < MEMORY_SIZE_WORDS) begin
                    bus.mem_r_data <= mem[bus.mem_r_addr[9:2]];
                    bus.mem_state  <= MEMORY_STATE_SUCCESS;
                end else bus.mem_state <= MEMORY_STATE_OUT_OF_BOUNDS;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic set_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
    endtask

    // Present a request at a negedge; returns at the negedge after the accepting edge
    task automatic launch(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        int n;
        @(negedge clk);
        set_req(we, addr, size, uns, wdata);
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        chk({tag, " ready"}, {31'h0, bus.req_ready}, 32'h1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic good(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] e_addr, input logic [3:0] e_strb, input logic [31:0] e_wd,
                        input logic [1:0] e_code, input logic [31:0] e_rdata);
        launch(tag, we, addr, size, uns, wdata);
        chk({tag, " issue en"}, {30'h0, bus.mem_w_en, bus.mem_r_en}, we ? 32'h2 : 32'h1);
        chk({tag, " addr"}, we ? bus.mem_w_addr : bus.mem_r_addr, e_addr);
        if (we) begin
            chk({tag, " strb"}, {28'h0, bus.mem_w_strb}, {28'h0, e_strb});
            chk({tag, " wdata"}, bus.mem_w_data, e_wd);
        end
        chk({tag, " early rsp"}, {31'h0, bus.rsp_valid}, 32'h0);
        @(negedge clk);
        chk({tag, " rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
        chk({tag, " code"}, {30'h0, bus.rsp_code}, {30'h0, e_code});
        chk({tag, " err"}, {31'h0, bus.rsp_err}, {31'h0, e_code != MEMORY_STATE_SUCCESS});
        chk({tag, " rdata"}, bus.rsp_rdata, e_rdata);
    endtask

    task automatic bad(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic [1:0] e_code);
        launch(tag, we, addr, size, 1'b0, 32'hFFFF_FFFF);
        chk({tag, " rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
        chk({tag, " err"}, {31'h0, bus.rsp_err}, 32'h1);
        chk({tag, " code"}, {30'h0, bus.rsp_code}, {30'h0, e_code});
        chk({tag, " rdata"}, bus.rsp_rdata, 32'h0);
        chk({tag, " no mem"}, {30'h0, bus.mem_w_en, bus.mem_r_en}, 32'h0);
        @(negedge clk);
        chk({tag, " done"}, {29'h0, bus.rsp_valid, bus.mem_w_en, bus.mem_r_en}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int acc_cyc [0:7];
    logic [31:0] b2b_exp [0:7];
    int req_idx, rsp_idx;
    logic acc;

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0;
        bus.req_size = 2'b00; bus.req_unsigned = 1'b0; bus.req_wdata = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst ready", {31'h0, bus.req_ready}, 32'h0);
        chk("rst rsp", {29'h0, bus.rsp_valid, bus.rsp_err, 1'b0}, 32'h0);
        chk("rst code", {30'h0, bus.rsp_code}, {30'h0, MEMORY_STATE_SUCCESS});
        chk("rst rdata", bus.rsp_rdata, 32'h0);
        chk("rst mem", {30'h0, bus.mem_r_en, bus.mem_w_en} | bus.mem_r_addr | bus.mem_w_addr
                       | bus.mem_w_data | {28'h0, bus.mem_w_strb}, 32'h0);
        rst = 1'b0;
        #1 chk("ready after rst", {31'h0, bus.req_ready}, 32'h1);

        // Word store/load
        good("SW", 1, 32'h1010, LSU_SIZE_WORD, 0, 32'hDEAD_BEEF, 32'h10, 4'hF, 32'hDEAD_BEEF,
             MEMORY_STATE_SUCCESS, 32'h0);
        good("LW", 0, 32'h1010, LSU_SIZE_WORD, 0, 32'h0, 32'h10, 4'h0, 32'h0,
             MEMORY_STATE_SUCCESS, 32'hDEAD_BEEF);
        // Byte store at lane 3, signed/unsigned reload
        good("SB", 1, 32'h1013, LSU_SIZE_BYTE, 0, 32'h0000_0080, 32'h10, 4'h8, 32'h8080_8080,
             MEMORY_STATE_SUCCESS, 32'h0);
        good("LB", 0, 32'h1013, LSU_SIZE_BYTE, 0, 32'h0, 32'h10, 4'h0, 32'h0,
             MEMORY_STATE_SUCCESS, 32'hFFFF_FF80);
        good("LBU", 0, 32'h1013, LSU_SIZE_BYTE, 1, 32'h0, 32'h10, 4'h0, 32'h0,
             MEMORY_STATE_SUCCESS, 32'h0000_0080);
        good("LW merged", 0, 32'h1010, LSU_SIZE_WORD, 0, 32'h0, 32'h10, 4'h0, 32'h0,
             MEMORY_STATE_SUCCESS, 32'h80AD_BEEF);
        // Halfword at upper lane
        good("SH", 1, 32'h1016, LSU_SIZE_HALF, 0, 32'h1234_8123, 32'h14, 4'hC, 32'h8123_8123,
             MEMORY_STATE_SUCCESS, 32'h0);
        good("LH", 0, 32'h1016, LSU_SIZE_HALF, 0, 32'h0, 32'h14, 4'h0, 32'h0,
             MEMORY_STATE_SUCCESS, 32'hFFFF_8123);
        good("LHU", 0, 32'h1016, LSU_SIZE_HALF, 1, 32'h0, 32'h14, 4'h0, 32'h0,
             MEMORY_STATE_SUCCESS, 32'h0000_8123);

        // Local rejections
        bad("LH odd", 0, 32'h1011, LSU_SIZE_HALF, MEMORY_STATE_ALIGNMENT);
        bad("LW off2", 0, 32'h1012, LSU_SIZE_WORD, MEMORY_STATE_ALIGNMENT);
        bad("size11", 1, 32'h1010, LSU_SIZE_ILLEGAL, MEMORY_STATE_ALIGNMENT);
        bad("size11 below", 0, 32'h0FFC, LSU_SIZE_ILLEGAL, MEMORY_STATE_ALIGNMENT);
        bad("LW below", 0, 32'h0FFC, LSU_SIZE_WORD, MEMORY_STATE_OUT_OF_BOUNDS);

        // Memory-side out of bounds passes through, then status recovers
        good("LW oob", 0, 32'h1000 + 4*MEMORY_SIZE_WORDS, LSU_SIZE_WORD, 0, 32'h0, 32'h400, 4'h0,
             32'h0, MEMORY_STATE_OUT_OF_BOUNDS, 32'h0);
        good("LW after oob", 0, 32'h1010, LSU_SIZE_WORD, 0, 32'h0, 32'h10, 4'h0, 32'h0,
             MEMORY_STATE_SUCCESS, 32'h80AD_BEEF);

        // Back-to-back: store/load pairs with req_valid held
        for (int k = 0; k < 8; k++)
            b2b_exp[k] = (k % 2 == 1) ? (32'h5A5A_0000 | (k - 1)) : 32'h0;
        @(negedge clk);
        set_req(1, 32'h1040, LSU_SIZE_WORD, 0, 32'h5A5A_0000);
        req_idx = 0; rsp_idx = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.rsp_valid) begin
                if (rsp_idx < 8) begin
                    chk("b2b latency", c, acc_cyc[rsp_idx] + 2);
                    chk("b2b rdata", bus.rsp_rdata, b2b_exp[rsp_idx]);
                    rsp_idx++;
                end else chk("b2b extra rsp", 32'h1, 32'h0);
            end
            acc = bus.req_valid && bus.req_ready;
            if (acc) begin acc_cyc[req_idx] = c; req_idx++; end
            @(posedge clk); #1;
            if (acc) begin
                if (req_idx < 8)
                    set_req(req_idx[0] ? 1'b0 : 1'b1, 32'h1040 + 4*(req_idx/2), LSU_SIZE_WORD, 0,
                            32'h5A5A_0000 | req_idx);
                else bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b rsp count", rsp_idx, 8);
        for (int k = 1; k < 8; k++) chk("b2b cadence", acc_cyc[k] - acc_cyc[k-1], 2);

        // clk_enable dropped during ISSUE for 3 cycles
        launch("stall", 0, 32'h1010, LSU_SIZE_WORD, 0, 32'h0);
        chk("stall issue", {31'h0, bus.mem_r_en}, 32'h1);
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall frozen", {29'h0, bus.mem_r_en, bus.rsp_valid, bus.req_ready}, 32'h0);
        end
        clk_enable = 1'b1;
        #1 chk("stall reissue", {31'h0, bus.mem_r_en}, 32'h1);
        @(negedge clk);
        chk("stall rsp", {31'h0, bus.rsp_valid}, 32'h1);
        chk("stall rdata", bus.rsp_rdata, 32'h80AD_BEEF);
        @(negedge clk);
        chk("stall single", {31'h0, bus.rsp_valid}, 32'h0);

        // Reset during ISSUE aborts without a response
        launch("rst mid", 1, 32'h1030, LSU_SIZE_WORD, 0, 32'h1111_1111);
        chk("rst mid issue", {31'h0, bus.mem_w_en}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst mid rsp", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst mid outs", {29'h0, bus.req_ready, bus.mem_r_en, bus.mem_w_en}, 32'h0);
        chk("rst mid strb", {28'h0, bus.mem_w_strb}, 32'h0);
        rst = 1'b0;
        #1 chk("rst mid ready", {31'h0, bus.req_ready}, 32'h1);
        @(negedge clk);
        chk("rst mid quiet", {31'h0, bus.rsp_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
